// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: round-robin front end that shares a single add_float unit
// among NUM_REQ clients. One operation is in flight at a time: grant, issue a
// one-cycle start, wait for the adder's done edge (or abort via watchdog),
// then hold the tagged response until the consumer takes it.
module fpu_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int IDX_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*64-1:0]  req_op1,
  input  logic [NUM_REQ*64-1:0]  req_op2,
  input  logic [NUM_REQ-1:0]     req_op_sub,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDX_W-1:0]       resp_idx,
  output logic [63:0]            resp_out,
  output logic                   resp_nan,
  output logic                   resp_overflow,
  output logic                   resp_underflow,
  output logic                   resp_zero,
  output logic                   resp_timeout,
  output logic                   fpu_start,
  output logic [63:0]            fpu_op1,
  output logic [63:0]            fpu_op2,
  output logic                   fpu_op_sub,
  input  logic [63:0]            fpu_out,
  input  logic                   fpu_nan,
  input  logic                   fpu_overflow,
  input  logic                   fpu_underflow,
  input  logic                   fpu_zero,
  input  logic                   fpu_done
);

  localparam int               CNT_W     = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [63:0]      QNAN      = 64'h7ff8000000000000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t next_state;

  // Per-requester views of the flattened operand buses
  logic [63:0] op1_arr [NUM_REQ];
  logic [63:0] op2_arr [NUM_REQ];

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_found;

  logic [IDX_W-1:0] tag_q;
  logic [63:0]      op1_q;
  logic [63:0]      op2_q;
  logic             sub_q;

  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_next;
  logic             timeout_hit;
  logic             done_q;
  logic             done_rise;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op1_arr[i] = req_op1[i*64 +: 64];
    assign op2_arr[i] = req_op2[i*64 +: 64];
  end

  // Round-robin search: first valid requester after the last one served
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Watchdog increment saturates at the abort point; a done edge is a
  // high level now against a low registered sample from the previous cycle
  always_comb begin
    wd_next     = (wd_cnt == CNT_LIMIT) ? wd_cnt : wd_cnt + CNT_W'(1);
    timeout_hit = (wd_next == CNT_LIMIT);
    done_rise   = fpu_done && !done_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; completion is checked before timeout so it wins a tie
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (grant_found) next_state = ISSUE;
      ISSUE: next_state = WAIT;
      WAIT:  if (done_rise || timeout_hit) next_state = RESP;
      RESP:  if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs; the grant is suppressed while reset is held
  always_comb begin
    req_ready  = '0;
    fpu_start  = (state == ISSUE);
    resp_valid = (state == RESP);
    if (state == IDLE && grant_found && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Latch the granted request; these registers feed the adder until the next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      tag_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      sub_q      <= 1'b0;
    end else if (state == IDLE && grant_found) begin
      last_grant <= grant_idx;
      tag_q      <= grant_idx;
      op1_q      <= op1_arr[grant_idx];
      op2_q      <= op2_arr[grant_idx];
      sub_q      <= req_op_sub[grant_idx];
    end
  end

  // Watchdog counter and done sampler; the sampler runs in every state so a
  // level already high when WAIT begins never looks like a fresh edge
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fpu_done;
      if (state == ISSUE) begin
        wd_cnt <= '0;
      end else if (state == WAIT) begin
        wd_cnt <= wd_next;
      end
    end
  end

  // Response capture: adder result on completion, quiet NaN on watchdog abort
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_out       <= '0;
      resp_nan       <= 1'b0;
      resp_overflow  <= 1'b0;
      resp_underflow <= 1'b0;
      resp_zero      <= 1'b0;
      resp_timeout   <= 1'b0;
    end else if (state == WAIT) begin
      if (done_rise) begin
        resp_out       <= fpu_out;
        resp_nan       <= fpu_nan;
        resp_overflow  <= fpu_overflow;
        resp_underflow <= fpu_underflow;
        resp_zero      <= fpu_zero;
        resp_timeout   <= 1'b0;
      end else if (timeout_hit) begin
        resp_out       <= QNAN;
        resp_nan       <= 1'b1;
        resp_overflow  <= 1'b0;
        resp_underflow <= 1'b0;
        resp_zero      <= 1'b0;
        resp_timeout   <= 1'b1;
      end
    end
  end

  assign resp_idx   = tag_q;
  assign fpu_op1    = op1_q;
  assign fpu_op2    = op2_q;
  assign fpu_op_sub = sub_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb_fpu_add_arbiter: drives the arbiter against a behavioural add_float
// stand-in and checks grants, latency, tagging and watchdog aborts.
module tb_fpu_add_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int IW  = 2;

  logic            clk        = 1'b0;
  logic            rst        = 1'b1;
  logic [N-1:0]    req_valid  = '0;
  logic [N-1:0]    req_ready;
  logic [N*64-1:0] req_op1    = '0;
  logic [N*64-1:0] req_op2    = '0;
  logic [N-1:0]    req_op_sub = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [IW-1:0]   resp_idx;
  logic [63:0]     resp_out;
  logic            resp_nan, resp_overflow, resp_underflow, resp_zero, resp_timeout;
  logic            fpu_start;
  logic [63:0]     fpu_op1, fpu_op2;
  logic            fpu_op_sub;
  logic [63:0]     fpu_out       = '0;
  logic            fpu_nan       = 1'b0;
  logic            fpu_overflow  = 1'b0;
  logic            fpu_underflow = 1'b0;
  logic            fpu_zero      = 1'b0;
  logic            fpu_done;

  int checks = 0;
  int errors = 0;
  int model_last = N - 1;

  always #5 clk = ~clk;

  fpu_add_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_op_sub(req_op_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_idx(resp_idx),
    .resp_out(resp_out), .resp_nan(resp_nan), .resp_overflow(resp_overflow),
    .resp_underflow(resp_underflow), .resp_zero(resp_zero), .resp_timeout(resp_timeout),
    .fpu_start(fpu_start), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_op_sub(fpu_op_sub),
    .fpu_out(fpu_out), .fpu_nan(fpu_nan), .fpu_overflow(fpu_overflow),
    .fpu_underflow(fpu_underflow), .fpu_zero(fpu_zero), .fpu_done(fpu_done)
  );

  // IEEE double add/sub via the simulator's real arithmetic
  function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic sub);
    real r;
    r = sub ? ($bitstoreal(a) - $bitstoreal(b)) : ($bitstoreal(a) + $bitstoreal(b));
    return $realtobits(r);
  endfunction

  // {nan, overflow, underflow, zero} classification of an add result
  function automatic logic [3:0] ref_flags(input logic [63:0] a, input logic [63:0] b, input logic [63:0] r);
    logic r_nan, r_inf, fin, r_sub, r_zero;
    r_nan  = (r[62:52] == 11'h7ff) && (r[51:0] != 52'd0);
    r_inf  = (r[62:52] == 11'h7ff) && (r[51:0] == 52'd0);
    fin    = (a[62:52] != 11'h7ff) && (b[62:52] != 11'h7ff);
    r_sub  = (r[62:52] == 11'd0) && (r[51:0] != 52'd0);
    r_zero = (r[62:0] == 63'd0);
    return {r_nan, r_inf && fin, r_sub, r_zero};
  endfunction

  function automatic logic [63:0] rand_fp();
    return {1'($urandom_range(0, 1)), 11'(1013 + $urandom_range(0, 20)), 20'($urandom), 32'($urandom)};
  endfunction

  // Adder stand-in: answers stub_lat cycles after start, holds done high until the next start
  int          stub_lat    = 0;
  int          stub_cnt    = 0;
  bit          stub_silent = 1'b0;
  bit          stub_busy   = 1'b0;
  logic        stub_done   = 1'b0;
  logic        stray_done  = 1'b0;
  logic [63:0] s_op1, s_op2, s_res;
  logic        s_sub;

  assign fpu_done = stub_done | stray_done;

  always @(negedge clk) begin
    if (rst) begin
      stub_busy = 1'b0;
      stub_done = 1'b0;
    end else if (fpu_start) begin
      s_op1     = fpu_op1;
      s_op2     = fpu_op2;
      s_sub     = fpu_op_sub;
      stub_cnt  = stub_lat;
      stub_busy = !stub_silent;
      stub_done = 1'b0;
    end else if (stub_busy) begin
      if (stub_cnt == 0) begin
        s_res   = ref_add(s_op1, s_op2, s_sub);
        fpu_out = s_res;
        {fpu_nan, fpu_overflow, fpu_underflow, fpu_zero} = ref_flags(s_op1, s_op2, s_res);
        stub_done = 1'b1;
        stub_busy = 1'b0;
      end else begin
        stub_cnt = stub_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [N-1:0]  grant;
    logic [N-1:0]  ready_next;
    logic          start_now;
    logic [63:0]   op1;
    logic [63:0]   op2;
    logic          sub;
    int            extra_starts;
    bit            resp_seen;
    int            resp_lat;
    logic [IW-1:0] idx;
    logic [63:0]   out;
    logic [3:0]    flags;
    logic          tmo;
  } obs_t;

  // Presents a request in IDLE and records what the DUT does; makes no judgements
  task automatic observe_op(input logic [N-1:0] valid, input bit keep_valid, output obs_t o);
    req_valid = valid;
    #1;
    o.grant = req_ready;
    @(posedge clk); #1;
    o.ready_next = req_ready;
    if (!keep_valid) req_valid = '0;
    o.start_now    = fpu_start;
    o.op1          = fpu_op1;
    o.op2          = fpu_op2;
    o.sub          = fpu_op_sub;
    o.extra_starts = 0;
    o.resp_seen    = 1'b0;
    o.resp_lat     = 0;
    for (int k = 1; k <= TMO + 20 && !o.resp_seen; k++) begin
      @(posedge clk); #1;
      if (fpu_start) o.extra_starts++;
      if (resp_valid) begin
        o.resp_seen = 1'b1;
        o.resp_lat  = k;
      end
    end
    o.idx   = resp_idx;
    o.out   = resp_out;
    o.flags = {resp_nan, resp_overflow, resp_underflow, resp_zero};
    o.tmo   = resp_timeout;
  endtask

  task automatic accept_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic randomize_ops();
    for (int s = 0; s < N; s++) begin
      req_op1[s*64 +: 64] = rand_fp();
      req_op2[s*64 +: 64] = rand_fp();
      req_op_sub[s]       = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({req_ready, resp_valid, fpu_start, fpu_op_sub} !== '0) begin errors++;
      $display("[TB] FAIL reset_ctrl got %b exp 0", {req_ready, resp_valid, fpu_start, fpu_op_sub}); end
    checks++; if ({resp_nan, resp_overflow, resp_underflow, resp_zero, resp_timeout, resp_idx} !== '0) begin errors++;
      $display("[TB] FAIL reset_flags got %b exp 0", {resp_nan, resp_overflow, resp_underflow, resp_zero, resp_timeout, resp_idx}); end
    checks++; if (resp_out !== 64'd0) begin errors++;
      $display("[TB] FAIL reset_resp_out got %h exp 0", resp_out); end
    checks++; if ({fpu_op1, fpu_op2} !== 128'd0) begin errors++;
      $display("[TB] FAIL reset_fpu_ops got %h %h exp 0", fpu_op1, fpu_op2); end
    rst = 1'b0;
    @(posedge clk); #1;
    model_last = N - 1;
  endtask

  task automatic test_single_add();
    obs_t o;
    randomize_ops();
    req_op1[2*64 +: 64] = 64'h3FF0000000000000;
    req_op2[2*64 +: 64] = 64'h4000000000000000;
    req_op_sub[2]       = 1'b0;
    stub_lat = 3;
    observe_op(4'b0100, 1'b0, o);
    model_last = 2;
    checks++; if (o.grant !== 4'b0100) begin errors++;
      $display("[TB] FAIL single_grant got %b exp 0100", o.grant); end
    checks++; if (o.ready_next !== 4'b0000) begin errors++;
      $display("[TB] FAIL single_ready_one_cycle got %b exp 0000", o.ready_next); end
    checks++; if ({o.start_now, o.extra_starts} !== {1'b1, 32'd0}) begin errors++;
      $display("[TB] FAIL single_start_pulse got %b/%0d exp 1/0", o.start_now, o.extra_starts); end
    checks++; if ({o.op1, o.op2, o.sub} !== {64'h3FF0000000000000, 64'h4000000000000000, 1'b0}) begin errors++;
      $display("[TB] FAIL single_fpu_ops got %h %h %b", o.op1, o.op2, o.sub); end
    checks++; if (!o.resp_seen || o.resp_lat != stub_lat + 2) begin errors++;
      $display("[TB] FAIL single_latency got %0d exp %0d", o.resp_lat, stub_lat + 2); end
    checks++; if (o.idx !== 2'd2) begin errors++;
      $display("[TB] FAIL single_idx got %0d exp 2", o.idx); end
    checks++; if (o.out !== 64'h4008000000000000) begin errors++;
      $display("[TB] FAIL single_out got %h exp 4008000000000000", o.out); end
    checks++; if ({o.flags, o.tmo} !== 5'b0) begin errors++;
      $display("[TB] FAIL single_flags got %b exp 00000", {o.flags, o.tmo}); end
    checks++; if (fpu_op1 !== 64'h3FF0000000000000) begin errors++;
      $display("[TB] FAIL single_op_hold got %h exp 3FF0000000000000", fpu_op1); end
    accept_resp();
    checks++; if (resp_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL single_resp_drop got %b exp 0", resp_valid); end
  endtask

  task automatic test_sub_backpressure();
    obs_t o;
    randomize_ops();
    req_op1[0 +: 64] = 64'h4008000000000000;
    req_op2[0 +: 64] = 64'h3FF0000000000000;
    req_op_sub[0]    = 1'b1;
    stub_lat = 1;
    observe_op(4'b0001, 1'b0, o);
    model_last = 0;
    checks++; if (o.grant !== 4'b0001) begin errors++;
      $display("[TB] FAIL bp_grant got %b exp 0001", o.grant); end
    checks++; if (!o.resp_seen || o.out !== 64'h4000000000000000 || o.idx !== 2'd0) begin errors++;
      $display("[TB] FAIL bp_result got %h idx %0d exp 4000000000000000 idx 0", o.out, o.idx); end
    req_valid = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if ({resp_valid, req_ready, fpu_start} !== {1'b1, 4'b0000, 1'b0} || resp_out !== 64'h4000000000000000) begin errors++;
        $display("[TB] FAIL bp_hold cyc %0d got v=%b rdy=%b st=%b out=%h", c, resp_valid, req_ready, fpu_start, resp_out); end
    end
    accept_resp();
    checks++; if (req_ready !== 4'b0010) begin errors++;
      $display("[TB] FAIL bp_next_grant got %b exp 0010", req_ready); end
    req_valid = '0;
    #1;
  endtask

  task automatic test_round_robin();
    obs_t o;
    logic [63:0] e_out;
    logic [N-1:0] e_grant;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      randomize_ops();
      stub_lat = $urandom_range(0, 4);
      e_grant = '0;
      e_grant[n % N] = 1'b1;
      e_out = ref_add(req_op1[(n % N)*64 +: 64], req_op2[(n % N)*64 +: 64], req_op_sub[n % N]);
      observe_op(4'b1111, 1'b1, o);
      checks++; if (o.grant !== e_grant) begin errors++;
        $display("[TB] FAIL rr_grant op %0d got %b exp %b", n, o.grant, e_grant); end
      checks++; if (!o.resp_seen || o.idx !== IW'(n % N) || o.out !== e_out) begin errors++;
        $display("[TB] FAIL rr_resp op %0d got idx %0d out %h exp idx %0d out %h", n, o.idx, o.out, n % N, e_out); end
      accept_resp();
    end
    req_valid = '0;
    #1;
    model_last = 3;
  endtask

  task automatic test_timeout();
    obs_t o;
    randomize_ops();
    stub_silent = 1'b1;
    stray_done  = 1'b1;
    observe_op(4'b1000, 1'b0, o);
    model_last = 3;
    checks++; if (o.grant !== 4'b1000) begin errors++;
      $display("[TB] FAIL tmo_grant got %b exp 1000", o.grant); end
    checks++; if (!o.resp_seen || o.resp_lat != TMO) begin errors++;
      $display("[TB] FAIL tmo_latency got %0d seen %b exp %0d", o.resp_lat, o.resp_seen, TMO); end
    checks++; if ({o.tmo, o.flags} !== 5'b11000 || o.out !== 64'h7FF8000000000000) begin errors++;
      $display("[TB] FAIL tmo_resp got tmo/flags %b out %h exp 11000 7FF8000000000000", {o.tmo, o.flags}, o.out); end
    checks++; if (o.idx !== 2'd3) begin errors++;
      $display("[TB] FAIL tmo_idx got %0d exp 3", o.idx); end
    accept_resp();
    stray_done = 1'b0;
    @(posedge clk); #1;
    stray_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++; if ({resp_valid, fpu_start} !== 2'b00) begin errors++;
        $display("[TB] FAIL tmo_stray_done cyc %0d got v=%b st=%b exp 00", c, resp_valid, fpu_start); end
    end
    stray_done  = 1'b0;
    stub_silent = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    int resp_count;
    logic [63:0] e_out;
    stub_silent = 1'b1;
    randomize_ops();
    req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({req_ready, resp_valid, fpu_start, fpu_op_sub, resp_nan, resp_overflow, resp_underflow, resp_zero, resp_timeout, resp_idx} !== '0) begin errors++;
      $display("[TB] FAIL rstw_ctrl got %b exp 0", {req_ready, resp_valid, fpu_start, fpu_op_sub, resp_timeout, resp_idx}); end
    checks++; if ({resp_out, fpu_op1, fpu_op2} !== 192'd0) begin errors++;
      $display("[TB] FAIL rstw_data got %h %h %h exp 0", resp_out, fpu_op1, fpu_op2); end
    resp_count = 0;
    for (int c = 0; c < TMO + 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid) resp_count++;
    end
    checks++; if (resp_count != 0) begin errors++;
      $display("[TB] FAIL rstw_no_resp got %0d responses exp 0", resp_count); end
    stub_silent = 1'b0;
    stub_lat = 2;
    e_out = ref_add(req_op1[0 +: 64], req_op2[0 +: 64], req_op_sub[0]);
    observe_op(4'b1111, 1'b0, o);
    model_last = 0;
    checks++; if (o.grant !== 4'b0001) begin errors++;
      $display("[TB] FAIL rstw_next_grant got %b exp 0001", o.grant); end
    checks++; if (!o.resp_seen || o.out !== e_out || o.idx !== 2'd0) begin errors++;
      $display("[TB] FAIL rstw_next_resp got %h idx %0d exp %h idx 0", o.out, o.idx, e_out); end
    accept_resp();
  endtask

  task automatic test_overflow();
    obs_t o;
    randomize_ops();
    req_op1[1*64 +: 64] = 64'h7FEFFFFFFFFFFFFF;
    req_op2[1*64 +: 64] = 64'h7FEFFFFFFFFFFFFF;
    req_op_sub[1]       = 1'b0;
    stub_lat = 2;
    observe_op(4'b0010, 1'b0, o);
    model_last = 1;
    checks++; if (!o.resp_seen || o.out !== 64'h7FF0000000000000) begin errors++;
      $display("[TB] FAIL ovf_out got %h exp 7FF0000000000000", o.out); end
    checks++; if ({o.flags, o.tmo} !== 5'b01000) begin errors++;
      $display("[TB] FAIL ovf_flags got %b exp 01000", {o.flags, o.tmo}); end
    accept_resp();
  endtask

  task automatic test_random();
    obs_t o;
    logic [N-1:0] mask, e_grant;
    logic [63:0] e_out;
    int g, bp;
    for (int t = 0; t < 20; t++) begin
      randomize_ops();
      mask = N'($urandom_range(1, (1 << N) - 1));
      g = -1;
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && mask[(model_last + k) % N]) g = (model_last + k) % N;
      end
      e_grant = '0;
      e_grant[g] = 1'b1;
      e_out = ref_add(req_op1[g*64 +: 64], req_op2[g*64 +: 64], req_op_sub[g]);
      stub_lat = $urandom_range(0, 5);
      observe_op(mask, 1'b0, o);
      checks++; if (o.grant !== e_grant) begin errors++;
        $display("[TB] FAIL rand_grant op %0d mask %b got %b exp %b", t, mask, o.grant, e_grant); end
      checks++; if (!o.resp_seen || o.resp_lat != stub_lat + 2 || o.extra_starts != 0) begin errors++;
        $display("[TB] FAIL rand_timing op %0d got lat %0d starts %0d exp lat %0d starts 0", t, o.resp_lat, o.extra_starts, stub_lat + 2); end
      checks++; if (o.idx !== IW'(g) || o.out !== e_out || o.flags !== ref_flags(req_op1[g*64 +: 64], req_op2[g*64 +: 64], e_out) || o.tmo !== 1'b0) begin errors++;
        $display("[TB] FAIL rand_resp op %0d got idx %0d out %h fl %b exp idx %0d out %h", t, o.idx, o.out, o.flags, g, e_out); end
      model_last = g;
      bp = $urandom_range(0, 3);
      repeat (bp) begin @(posedge clk); #1; end
      accept_resp();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout simulation did not finish in time");
    $fatal(1, "[TB] stopped");
  end

  initial begin
    test_reset();
    test_single_add();
    test_sub_backpressure();
    test_round_robin();
    test_timeout();
    test_reset_mid_wait();
    test_overflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
